// File: rtl/instruction_encoder.sv
// Packs decoded instruction records into 32-bit MIPS words and streams them into
// instruction memory from BASE_ADDRESS, flagging unsupported encodings and overflow.

package instruction_encoder_pkg;
    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] immediate;
        logic [25:0] address;
    } instruction_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUBU    = 6'h23;
endpackage

module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_3000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  inValid,
    output logic                  inReady,
    input  instruction_t          inInstruction,
    input  logic                  inLast,
    output logic                  memWriteEnable,
    input  logic                  memWriteReady,
    output logic [31:0]           memWriteAddress,
    output logic [31:0]           memWriteData,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [31:0]           errorAddress,
    output logic [ADDR_WIDTH:0]   wordCount
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH
    } state_t;

    localparam logic [ADDR_WIDTH:0] LAST_IDX = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH:0] ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_WIDTH:0] idx_q, idx_d;
    logic [ADDR_WIDTH:0] cnt_q, cnt_d;
    logic                wen_q, wen_d;
    logic [31:0]         waddr_q, waddr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [31:0]         erraddr_q, erraddr_d;

    logic                accept;
    logic                wr_fire;
    logic                last_slot;
    logic [32:0]         enc;
    logic [31:0]         slot_addr;

    // Returns {illegal, word}; illegal records encode as an all-zero nop.
    function automatic logic [32:0] encode(input instruction_t r);
        logic [31:0] w;
        logic        bad;
        w   = 32'h0;
        bad = 1'b0;
        case (r.opcode)
            OP_SPECIAL: begin
                case (r.funct)
                    FN_ADDU, FN_SUBU: w = {r.opcode, r.rs, r.rt, r.rd, r.shamt, r.funct};
                    FN_JR:            w = {r.opcode, r.rs, 15'd0, r.funct};
                    FN_SYSCALL:       w = {r.opcode, 20'd0, r.funct};
                    default:          bad = 1'b1;
                endcase
            end
            OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE:
                w = {r.opcode, r.rs, r.rt, r.immediate};
            OP_LUI:  w = {r.opcode, 5'd0, r.rt, r.immediate};
            OP_JAL:  w = {r.opcode, r.address};
            default: bad = 1'b1;
        endcase
        return {bad, w};
    endfunction

    assign inReady   = (state_q == S_LOAD) && (!wen_q || memWriteReady);
    assign accept    = inValid && inReady;
    assign wr_fire   = wen_q && memWriteReady;
    assign last_slot = (idx_q == LAST_IDX);
    assign enc       = encode(inInstruction);
    assign slot_addr = BASE_ADDRESS + {{(29 - ADDR_WIDTH){1'b0}}, idx_q, 2'b00};

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        wen_d     = wen_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        erraddr_d = erraddr_q;

        if (wr_fire) begin
            wen_d = 1'b0;
            cnt_d = cnt_q + ONE;
        end

        // A new accept refills the output slot in the same cycle the old word drains.
        if (accept) begin
            wen_d   = 1'b1;
            wdata_d = enc[31:0];
            waddr_d = slot_addr;
            idx_d   = idx_q + ONE;
            if ((enc[32] || (last_slot && !inLast)) && !err_q) begin
                err_d     = 1'b1;
                erraddr_d = slot_addr;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    idx_d     = '0;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    erraddr_d = 32'h0;
                end
            end
            S_LOAD: begin
                if (accept && (inLast || last_slot))
                    state_d = S_FLUSH;
            end
            S_FLUSH: begin
                if (wr_fire)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            wen_q     <= 1'b0;
            waddr_q   <= 32'h0;
            wdata_q   <= 32'h0;
            err_q     <= 1'b0;
            erraddr_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            wen_q     <= wen_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            erraddr_q <= erraddr_d;
        end
    end

    assign memWriteEnable  = wen_q;
    assign memWriteAddress = waddr_q;
    assign memWriteData    = wdata_q;
    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_FLUSH) && wr_fire;
    assign error           = err_q;
    assign errorAddress    = erraddr_q;
    assign wordCount       = cnt_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Randomized and directed bench for instruction_encoder against a field-arithmetic reference model.

module tb_instruction_encoder;
    import instruction_encoder_pkg::*;

    localparam int AW = 2;
    localparam int CAP = 1 << AW;
    localparam logic [31:0] BASE = 32'h0000_3000;

    logic         clk;
    logic         rst;
    logic         start;
    logic         inValid;
    logic         inReady;
    instruction_t inInstruction;
    logic         inLast;
    logic         memWriteEnable;
    logic         memWriteReady;
    logic [31:0]  memWriteAddress;
    logic [31:0]  memWriteData;
    logic         busy;
    logic         done;
    logic         error;
    logic [31:0]  errorAddress;
    logic [AW:0]  wordCount;

    instruction_encoder #(.ADDR_WIDTH(AW), .BASE_ADDRESS(BASE)) dut (
        .clock(clk), .reset(rst), .start(start),
        .inValid(inValid), .inReady(inReady), .inInstruction(inInstruction), .inLast(inLast),
        .memWriteEnable(memWriteEnable), .memWriteReady(memWriteReady),
        .memWriteAddress(memWriteAddress), .memWriteData(memWriteData),
        .busy(busy), .done(done), .error(error), .errorAddress(errorAddress),
        .wordCount(wordCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Observed memory writes, captured mid-cycle when the handshake is stable.
    logic [63:0]  obs_q[$];
    int           done_cnt = 0;
    bit           pend = 0;
    logic [31:0]  pend_a, pend_d;

    always @(negedge clk) begin
        if (rst) begin
            pend = 0;
        end else begin
            if (pend) begin
                check_eq("hold_wen",  {31'd0, memWriteEnable}, 32'd1);
                check_eq("hold_addr", memWriteAddress, pend_a);
                check_eq("hold_data", memWriteData, pend_d);
            end
            if (memWriteEnable && memWriteReady) begin
                obs_q.push_back({memWriteAddress, memWriteData});
                pend = 0;
            end else if (memWriteEnable) begin
                pend   = 1;
                pend_a = memWriteAddress;
                pend_d = memWriteData;
            end else begin
                pend = 0;
            end
            if (done) done_cnt++;
        end
    end

    // Reference encoding built from field weights rather than bit concatenation.
    task automatic ref_word(input instruction_t r, output logic [31:0] w, output bit ill);
        int unsigned op, rs, rt, rd, sh, fn, imm, adr;
        op = r.opcode; rs = r.rs; rt = r.rt; rd = r.rd; sh = r.shamt;
        fn = r.funct; imm = r.immediate; adr = r.address;
        ill = 0;
        w   = 0;
        if (op == 0) begin
            if (fn == 'h21 || fn == 'h23)
                w = rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + sh * (1 << 6) + fn;
            else if (fn == 'h08) w = rs * (1 << 21) + fn;
            else if (fn == 'h0C) w = fn;
            else ill = 1;
        end else if (op == 'h0D || op == 'h23 || op == 'h2B || op == 'h04 || op == 'h05) begin
            w = op * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + imm;
        end else if (op == 'h0F) begin
            w = op * (1 << 26) + rt * (1 << 16) + imm;
        end else if (op == 'h03) begin
            w = op * (1 << 26) + adr;
        end else begin
            ill = 1;
        end
    endtask

    function automatic instruction_t rand_rec();
        instruction_t r;
        int sel;
        r.rs = 5'($urandom); r.rt = 5'($urandom); r.rd = 5'($urandom);
        r.shamt = 5'($urandom); r.immediate = 16'($urandom); r.address = 26'($urandom);
        r.funct = 6'($urandom);
        sel = $urandom_range(0, 11);
        if (sel <= 3) begin
            r.opcode = 6'h00;
            case ($urandom_range(0, 4))
                0: r.funct = 6'h21;
                1: r.funct = 6'h23;
                2: r.funct = 6'h08;
                3: r.funct = 6'h0C;
                default: ;
            endcase
        end else begin
            case (sel)
                4:  r.opcode = 6'h0D;
                5:  r.opcode = 6'h23;
                6:  r.opcode = 6'h2B;
                7:  r.opcode = 6'h04;
                8:  r.opcode = 6'h05;
                9:  r.opcode = 6'h0F;
                10: r.opcode = 6'h03;
                default: r.opcode = 6'($urandom);
            endcase
        end
        return r;
    endfunction

    function automatic instruction_t mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                                        input logic [15:0] imm, input logic [25:0] adr);
        instruction_t r;
        r.opcode = op; r.rs = rs; r.rt = rt; r.rd = rd; r.shamt = sh;
        r.funct = fn; r.immediate = imm; r.address = adr;
        return r;
    endfunction

    instruction_t prog[$];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        obs_q.delete();
        done_cnt = 0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        check_eq("start_err_clr", {31'd0, error}, 32'd0);
        check_eq("start_eaddr_clr", errorAddress, 32'd0);
        check_eq("start_wc_clr", 32'(wordCount), 32'd0);
    endtask

    task automatic wait_idle(input bit rnd);
        int c = 0;
        while (busy && c < 500) begin
            memWriteReady = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            cyc();
            c++;
        end
        check_eq("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_result(input int exp_acc, input bit overflow);
        logic [31:0] w;
        bit          ill;
        int          fault = -1;
        check_eq("n_writes", obs_q.size(), exp_acc);
        for (int k = 0; k < exp_acc; k++) begin
            ref_word(prog[k], w, ill);
            if (ill && fault < 0) fault = k;
            if (k < obs_q.size()) begin
                check_eq("wr_addr", obs_q[k][63:32], BASE + 4 * k);
                check_eq("wr_data", obs_q[k][31:0], w);
            end
        end
        if (fault < 0 && overflow) fault = exp_acc - 1;
        check_eq("wordCount", 32'(wordCount), exp_acc);
        check_eq("error", {31'd0, error}, (fault >= 0) ? 32'd1 : 32'd0);
        check_eq("errorAddress", errorAddress, (fault >= 0) ? BASE + 4 * fault : 32'd0);
        check_eq("done_pulses", done_cnt, 1);
    endtask

    task automatic run_prog(input int n, input bit use_last, input bit rnd);
        int  acc = 0;
        int  c = 0;
        bit  took;
        bit  overflow;
        int  exp_acc;
        overflow = use_last ? (n > CAP) : (n >= CAP);
        exp_acc  = (n > CAP) ? CAP : n;
        do_start();
        inValid = 1'b0;
        while (acc < exp_acc && c < 2000) begin
            if (!inValid) inValid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            inInstruction = prog[acc];
            inLast        = use_last && (acc == n - 1);
            memWriteReady = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            start         = rnd && busy && ($urandom_range(0, 7) == 0);
            @(negedge clk);
            took = inValid && inReady;
            cyc();
            if (took) begin
                acc++;
                inValid = 1'b0;
            end
            c++;
        end
        start = 1'b0;
        check_eq("accepts", acc, exp_acc);
        if (overflow && n > exp_acc) begin
            inValid       = 1'b1;
            inInstruction = prog[exp_acc];
            inLast        = 1'b0;
            repeat (3) begin
                @(negedge clk);
                check_eq("refuse_after_ovf", {31'd0, inReady}, 32'd0);
                cyc();
            end
        end
        inValid = 1'b0;
        inLast  = 1'b0;
        wait_idle(rnd);
        check_result(exp_acc, overflow);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; inValid = 1'b0; inLast = 1'b0;
        memWriteReady = 1'b1; inInstruction = '0;
        #12;
        check_eq("rst_wen", {31'd0, memWriteEnable}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_error", {31'd0, error}, 32'd0);
        check_eq("rst_ready", {31'd0, inReady}, 32'd0);
        check_eq("rst_wc", 32'(wordCount), 32'd0);
        cyc();
        rst = 1'b0;
        cyc();

        // Idle: valid input is refused.
        inValid = 1'b1;
        @(negedge clk);
        check_eq("idle_refuse", {31'd0, inReady}, 32'd0);
        cyc();
        inValid = 1'b0;

        prog = '{mk(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'h0, 26'h0)};
        run_prog(1, 1'b1, 1'b0);
        if (obs_q.size() > 0) check_eq("t1_word", obs_q[0][31:0], 32'h0022_1821);

        prog = '{mk(6'h0D, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h1234, 26'h0),
                 mk(6'h23, 5'd29, 5'd9, 5'd0, 5'd0, 6'h0, 16'hFFFC, 26'h0)};
        run_prog(2, 1'b1, 1'b0);
        if (obs_q.size() > 1) begin
            check_eq("t2_w0", obs_q[0][31:0], 32'h3408_1234);
            check_eq("t2_w1", obs_q[1][31:0], 32'h8FA9_FFFC);
            check_eq("t2_a1", obs_q[1][63:32], 32'h0000_3004);
        end

        // Output stall with the next record held valid.
        do_start();
        memWriteReady = 1'b0;
        inValid = 1'b1; inInstruction = prog[0]; inLast = 1'b0;
        cyc();
        inInstruction = prog[1]; inLast = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_eq("stall_ready", {31'd0, inReady}, 32'd0);
            check_eq("stall_data", memWriteData, 32'h3408_1234);
            check_eq("stall_addr", memWriteAddress, 32'h0000_3000);
            cyc();
        end
        memWriteReady = 1'b1;
        cyc();
        inValid = 1'b0; inLast = 1'b0;
        wait_idle(1'b0);
        check_result(2, 1'b0);

        prog = '{mk(6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h000_0C00),
                 mk(6'h00, 5'd5, 5'd3, 5'd7, 5'd4, 6'h0C, 16'h0, 26'h0)};
        run_prog(2, 1'b1, 1'b0);
        if (obs_q.size() > 1) begin
            check_eq("t4_jal", obs_q[0][31:0], 32'h0C00_0C00);
            check_eq("t4_sys", obs_q[1][31:0], 32'h0000_000C);
        end

        prog = '{mk(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'h0, 26'h0),
                 mk(6'h0D, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h1234, 26'h0),
                 mk(6'h3F, 5'd1, 5'd1, 5'd1, 5'd1, 6'h1, 16'h1, 26'h1)};
        run_prog(3, 1'b1, 1'b0);
        if (obs_q.size() > 2) check_eq("t5_nop", obs_q[2][31:0], 32'h0);
        check_eq("t5_eaddr", errorAddress, 32'h0000_3008);

        prog.delete();
        for (int k = 0; k < 5; k++) prog.push_back(mk(6'h0F, 5'd3, 5'(k), 5'd0, 5'd0, 6'h0, 16'(k), 26'h0));
        run_prog(5, 1'b0, 1'b0);
        check_eq("t6_eaddr", errorAddress, 32'h0000_300C);

        for (int t = 0; t < 40; t++) begin
            int n;
            n = $urandom_range(1, 6);
            prog.delete();
            for (int k = 0; k < n; k++) prog.push_back(rand_rec());
            run_prog(n, 1'b1, 1'b1);
        end

        // Asynchronous reset in the middle of an output stall.
        do_start();
        memWriteReady = 1'b0;
        inValid = 1'b1; inLast = 1'b0; inInstruction = prog[0];
        cyc();
        inValid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_wen", {31'd0, memWriteEnable}, 32'd0);
        check_eq("arst_busy", {31'd0, busy}, 32'd0);
        check_eq("arst_wc", 32'(wordCount), 32'd0);
        cyc();
        rst = 1'b0;
        memWriteReady = 1'b1;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
